// File: rtl/collision_pkg.sv
`default_nettype none
// ============================================================================
// Module      : collision_pkg
// Description : Shared side indices, limits and the lowest-index priority
//               encoder used to build the per-side first-hit report.
// Revision    : 1.0 - initial release
// ============================================================================
package collision_pkg;

  // Side indices into the probe vector and the report fields.
  localparam int SIDE_L    = 0;
  localparam int SIDE_R    = 1;
  localparam int SIDE_T    = 2;
  localparam int SIDE_B    = 3;
  localparam int NUM_SIDES = 4;

  // Widest object vector the encoder accepts; narrower vectors are zero-extended.
  localparam int MAX_OBJ = 16;

  typedef logic [3:0] obj_idx_t;

  // Lowest set bit wins; an all-zero vector encodes as 0.
  function automatic obj_idx_t prio_enc(input logic [MAX_OBJ-1:0] vec);
    obj_idx_t idx;
    idx = '0;
    for (int i = MAX_OBJ - 1; i >= 0; i--) begin
      if (vec[i]) idx = i[3:0];
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_probe.sv
`default_nettype none
// ============================================================================
// Module      : edge_probe
// Description : Registered match of the scan position against one probe
//               point. Both operands arrive widened by one bit so a probe
//               beyond the counter range can never alias onto a real pixel.
//   clk       : pixel clock
//   rst       : synchronous active-low reset
//   i_h_cnt   : zero-extended pixel column
//   i_v_cnt   : zero-extended pixel line
//   i_probe_x : probe column (may exceed counter range)
//   i_probe_y : probe line   (may exceed counter range)
//   o_active  : probe matched on the previous cycle
// Revision    : 1.0 - initial release
// ============================================================================
module edge_probe #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_h_cnt,
  input  logic [W-1:0] i_v_cnt,
  input  logic [W-1:0] i_probe_x,
  input  logic [W-1:0] i_probe_y,
  output logic         o_active
);

  logic active_d;
  logic active_q;

  always_comb begin
    active_d = (i_h_cnt == i_probe_x) && (i_v_cnt == i_probe_y);
  end

  always_ff @(posedge clk) begin
    if (!rst) active_q <= 1'b0;
    else      active_q <= active_d;
  end

  assign o_active = active_q;

endmodule
`default_nettype wire

// File: rtl/collision_probe_unit.sv
`default_nettype none
// ============================================================================
// Module      : collision_probe_unit
// Description : Frame-synchronous ball collision detector. Four edge probes
//               sample object presence during scan-out; hits are accumulated
//               per side and object over a frame and published as a report
//               with a valid/ack handshake at the sync pixel.
//   clk       : pixel clock          rst     : sync active-low reset
//   enable    : accumulate hits      h_cnt   : pixel column
//   v_cnt     : pixel line           obj_hit : per-object presence
//   ball_x/y  : ball top-left        col_ack : consumer accepts report
//   col_valid : report pending       col_side: per-side hit (L,R,T,B)
//   col_obj   : [side*NUM_OBJ+obj]   col_first: per-side lowest object index
//   overrun   : sticky, a report was overwritten unacknowledged
// Revision    : 1.0 - initial release
// ============================================================================
module collision_probe_unit
  import collision_pkg::*;
#(
  parameter int NUM_OBJ   = 3,
  parameter int BALL_SIZE = 16,
  parameter int CNT_W     = 10,
  parameter int SYNC_LINE = 500
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [CNT_W-1:0]       h_cnt,
  input  logic [CNT_W-1:0]       v_cnt,
  input  logic [NUM_OBJ-1:0]     obj_hit,
  input  logic [CNT_W-1:0]       ball_x,
  input  logic [CNT_W-1:0]       ball_y,
  input  logic                   col_ack,
  output logic                   col_valid,
  output logic [3:0]             col_side,
  output logic [4*NUM_OBJ-1:0]   col_obj,
  output logic [15:0]            col_first,
  output logic                   overrun
);

  localparam int c_pw   = CNT_W + 1;
  localparam int c_ow   = NUM_SIDES * NUM_OBJ;
  localparam int c_half = BALL_SIZE / 2;

  logic [c_pw-1:0]      w_probe_x [NUM_SIDES];
  logic [c_pw-1:0]      w_probe_y [NUM_SIDES];
  logic [NUM_SIDES-1:0] probe_act_q;

  // Object presence and enable delayed to line up with the registered probe flags.
  logic [NUM_OBJ-1:0]   hit_d, hit_q;
  logic                 en_d, en_q;

  logic [c_ow-1:0]      work_d, work_q;
  logic [c_ow-1:0]      w_frame;
  logic [3:0]           w_side;
  logic                 w_pub;

  logic                 col_valid_d, col_valid_q;
  logic [3:0]           col_side_d, col_side_q;
  logic [c_ow-1:0]      col_obj_d, col_obj_q;
  logic [15:0]          col_first_d, col_first_q;
  logic                 overrun_d, overrun_q;

  // Probe coordinates in one extra bit so the right/bottom probes never wrap.
  always_comb begin
    w_probe_x[SIDE_L] = {1'b0, ball_x};
    w_probe_y[SIDE_L] = {1'b0, ball_y} + c_pw'(c_half);
    w_probe_x[SIDE_R] = {1'b0, ball_x} + c_pw'(BALL_SIZE);
    w_probe_y[SIDE_R] = {1'b0, ball_y} + c_pw'(c_half);
    w_probe_x[SIDE_T] = {1'b0, ball_x} + c_pw'(c_half);
    w_probe_y[SIDE_T] = {1'b0, ball_y};
    w_probe_x[SIDE_B] = {1'b0, ball_x} + c_pw'(c_half);
    w_probe_y[SIDE_B] = {1'b0, ball_y} + c_pw'(BALL_SIZE);
  end

  for (genvar gs = 0; gs < NUM_SIDES; gs++) begin : g_probe
    edge_probe #(.W(c_pw)) u_probe (
      .clk      (clk),
      .rst      (rst),
      .i_h_cnt  ({1'b0, h_cnt}),
      .i_v_cnt  ({1'b0, v_cnt}),
      .i_probe_x(w_probe_x[gs]),
      .i_probe_y(w_probe_y[gs]),
      .o_active (probe_act_q[gs])
    );
  end

  // Frame hits so far, including the pixel sampled on the previous cycle.
  always_comb begin
    w_frame = work_q;
    for (int s = 0; s < NUM_SIDES; s++) begin
      if (en_q && probe_act_q[s])
        w_frame[s*NUM_OBJ +: NUM_OBJ] = work_q[s*NUM_OBJ +: NUM_OBJ] | hit_q;
    end
    w_side = '0;
    for (int s = 0; s < NUM_SIDES; s++) begin
      w_side[s] = |w_frame[s*NUM_OBJ +: NUM_OBJ];
    end
  end

  assign w_pub = (v_cnt == CNT_W'(SYNC_LINE)) && (h_cnt == '0);

  always_comb begin
    hit_d       = obj_hit;
    en_d        = enable;
    work_d      = w_frame;
    col_valid_d = col_valid_q;
    col_side_d  = col_side_q;
    col_obj_d   = col_obj_q;
    col_first_d = col_first_q;
    overrun_d   = overrun_q;

    if (w_pub) begin
      // The sync pixel itself is still in the delay stage, so it lands in
      // the cleared accumulator next cycle and counts toward the next frame.
      work_d      = '0;
      col_obj_d   = w_frame;
      col_side_d  = w_side;
      for (int s = 0; s < NUM_SIDES; s++) begin
        col_first_d[s*4 +: 4] = prio_enc(MAX_OBJ'(w_frame[s*NUM_OBJ +: NUM_OBJ]));
      end
      col_valid_d = 1'b1;
      if (col_valid_q && !col_ack) overrun_d = 1'b1;
    end else if (col_ack && col_valid_q) begin
      col_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_q       <= '0;
      en_q        <= 1'b0;
      work_q      <= '0;
      col_valid_q <= 1'b0;
      col_side_q  <= '0;
      col_obj_q   <= '0;
      col_first_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      hit_q       <= hit_d;
      en_q        <= en_d;
      work_q      <= work_d;
      col_valid_q <= col_valid_d;
      col_side_q  <= col_side_d;
      col_obj_q   <= col_obj_d;
      col_first_q <= col_first_d;
      overrun_q   <= overrun_d;
    end
  end

  assign col_valid = col_valid_q;
  assign col_side  = col_side_q;
  assign col_obj   = col_obj_q;
  assign col_first = col_first_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_collision_probe_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_collision_probe_unit
// Description : Directed self-checking bench for collision_probe_unit with
//               NUM_OBJ=3, BALL_SIZE=16, CNT_W=10, SYNC_LINE=500.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_probe_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [2:0]  obj_hit;
  logic [9:0]  ball_x;
  logic [9:0]  ball_y;
  logic        col_ack;
  logic        col_valid;
  logic [3:0]  col_side;
  logic [11:0] col_obj;
  logic [15:0] col_first;
  logic        overrun;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  collision_probe_unit #(
    .NUM_OBJ  (3),
    .BALL_SIZE(16),
    .CNT_W    (10),
    .SYNC_LINE(500)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .obj_hit  (obj_hit),
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .col_ack  (col_ack),
    .col_valid(col_valid),
    .col_side (col_side),
    .col_obj  (col_obj),
    .col_first(col_first),
    .overrun  (overrun)
  );

  // Apply one pixel, clock it, then settle past the edge before checking.
  task automatic step(input logic [9:0] h, input logic [9:0] v, input logic [2:0] hit);
    h_cnt   = h;
    v_cnt   = v;
    obj_hit = hit;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        errs++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic chk_report(input string tag, input logic v, input logic [3:0] s,
                            input logic [11:0] o, input logic [15:0] f);
    chk({tag, ".valid"}, 32'(col_valid), 32'(v));
    chk({tag, ".side"},  32'(col_side),  32'(s));
    chk({tag, ".obj"},   32'(col_obj),   32'(o));
    chk({tag, ".first"}, 32'(col_first), 32'(f));
  endtask

  initial begin
    rst = 1'b0; enable = 1'b1; col_ack = 1'b0;
    ball_x = 10'd100; ball_y = 10'd200;
    h_cnt = '0; v_cnt = '0; obj_hit = '0;

    // Reset held with hits on the left probe and even a sync pixel.
    step(10'd100, 10'd208, 3'b111);
    step(10'd100, 10'd208, 3'b111);
    step(10'd0,   10'd500, 3'b111);
    step(10'd100, 10'd208, 3'b111);
    chk_report("rst", 1'b0, 4'h0, 12'h000, 16'h0000);
    chk("rst.overrun", 32'(overrun), 32'd0);

    rst = 1'b1;
    step(10'd0, 10'd0, 3'b000);
    step(10'd0, 10'd500, 3'b000);
    chk_report("first_pub", 1'b1, 4'h0, 12'h000, 16'h0000);
    col_ack = 1'b1; step(10'd0, 10'd0, 3'b000); col_ack = 1'b0;
    chk("ack_clears", 32'(col_valid), 32'd0);

    // Single hit: obj1 at left probe (100,208).
    step(10'd100, 10'd208, 3'b010);
    step(10'd0,   10'd0,   3'b000);
    step(10'd0,   10'd500, 3'b000);
    chk_report("single", 1'b1, 4'b0001, 12'h002, 16'h0001);

    // Priority: bottom obj0+obj2, right obj2, top obj1+obj2, off-probe noise.
    // Published while the previous report is still pending but acked on P.
    step(10'd108, 10'd216, 3'b101);
    step(10'd116, 10'd208, 3'b100);
    step(10'd108, 10'd200, 3'b110);
    step(10'd101, 10'd208, 3'b111);
    col_ack = 1'b1; step(10'd0, 10'd500, 3'b000); col_ack = 1'b0;
    chk_report("prio", 1'b1, 4'b1110, 12'hBA0, 16'h0120);
    chk("prio.overrun", 32'(overrun), 32'd0);

    // Second publish with no ack overwrites and flags overrun.
    step(10'd100, 10'd208, 3'b001);
    step(10'd0,   10'd500, 3'b000);
    chk_report("overwrite", 1'b1, 4'b0001, 12'h001, 16'h0000);
    chk("overrun_set", 32'(overrun), 32'd1);
    col_ack = 1'b1; step(10'd0, 10'd0, 3'b000);
    chk("ack_drop.valid", 32'(col_valid), 32'd0);
    chk("ack_drop.hold",  32'(col_obj),   32'h001);
    step(10'd0, 10'd0, 3'b000); col_ack = 1'b0;
    chk("ack_idle.valid", 32'(col_valid), 32'd0);

    // Boundary: right probe at 1031 is out of range; h=7 must not alias it.
    ball_x = 10'd1015; ball_y = 10'd200;
    step(10'd7,    10'd208, 3'b111);
    step(10'd1023, 10'd200, 3'b010);
    step(10'd1023, 10'd208, 3'b111);
    // Move ball so its left probe sits on the sync pixel and hit it there.
    ball_x = 10'd0; ball_y = 10'd492;
    step(10'd0, 10'd500, 3'b100);
    chk_report("wrap", 1'b1, 4'b0100, 12'h080, 16'h0100);
    col_ack = 1'b1; step(10'd0, 10'd0, 3'b000); col_ack = 1'b0;
    step(10'd0, 10'd0, 3'b000);
    step(10'd0, 10'd500, 3'b000);
    chk_report("p_pixel_next", 1'b1, 4'b0001, 12'h004, 16'h0002);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    col_ack = 1'b1; step(10'd0, 10'd0, 3'b000); col_ack = 1'b0;

    // Disabled frame: hits on every probe are ignored.
    ball_x = 10'd100; ball_y = 10'd200; enable = 1'b0;
    step(10'd100, 10'd208, 3'b111);
    step(10'd116, 10'd208, 3'b111);
    step(10'd108, 10'd200, 3'b111);
    step(10'd108, 10'd216, 3'b111);
    step(10'd0,   10'd500, 3'b000);
    chk_report("disabled", 1'b1, 4'h0, 12'h000, 16'h0000);
    col_ack = 1'b1; step(10'd0, 10'd0, 3'b000); col_ack = 1'b0;
    enable = 1'b1;

    // Reset mid-frame discards accumulated hits and clears overrun.
    step(10'd100, 10'd208, 3'b010);
    step(10'd0,   10'd0,   3'b000);
    rst = 1'b0; step(10'd0, 10'd0, 3'b000);
    chk("midrst.overrun", 32'(overrun), 32'd0);
    rst = 1'b1; step(10'd0, 10'd0, 3'b000);
    step(10'd0, 10'd500, 3'b000);
    chk_report("midrst", 1'b1, 4'h0, 12'h000, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/collision_probe_unit.md
Name: collision_probe_unit

Overview:
- Frame-synchronous collision detector between the ball and up to NUM_OBJ independently flagged screen objects (border, paddles, future bricks).
- Samples each object's per-pixel presence at four edge probe points around the ball during scan-out.
- Accumulates hits per side and per object over one frame, then publishes a registered collision report with a valid/ack handshake.
- Sits between pixel_gen (object presence) / vga_controller (counters) and Ball/Game; replaces the four ad-hoc CollisionX/Y flags.

Parameters:
- NUM_OBJ, 3, number of object presence channels (1..16)
- BALL_SIZE, 16, ball edge length in pixels; probes at 0, BALL_SIZE/2, BALL_SIZE
- CNT_W, 10, width of h_cnt/v_cnt/ball position
- SYNC_LINE, 500, v_cnt line at which the frame report is published (with h_cnt==0)

Ports:
- clk  in  1  pixel-domain clock (same clock driving h_cnt/v_cnt)
- rst  in  1  synchronous active-low reset
- enable  in  1  1 = probing active (play state); 0 = hits ignored, reports still published
- h_cnt  in  CNT_W  current pixel column
- v_cnt  in  CNT_W  current pixel line
- obj_hit  in  NUM_OBJ  per-object presence at (h_cnt, v_cnt)
- ball_x  in  CNT_W  ball top-left x
- ball_y  in  CNT_W  ball top-left y
- col_ack  in  1  consumer accepts current report
- col_valid  out  1  report pending
- col_side  out  4  OR over objects, bit0 left, bit1 right, bit2 top, bit3 bottom
- col_obj  out  4*NUM_OBJ  [side*NUM_OBJ + obj] hit matrix
- col_first  out  4*4  per side, lowest hitting object index (0 if none)
- overrun  out  1  sticky: a report was overwritten unacknowledged

Behaviour:
- Reset (rst==0 at posedge clk): all outputs 0, working accumulators 0.
- Probe points, computed in CNT_W+1 bits (no wrap):
  - left (ball_x, ball_y+BALL_SIZE/2)
  - right (ball_x+BALL_SIZE, ball_y+BALL_SIZE/2)
  - top (ball_x+BALL_SIZE/2, ball_y)
  - bottom (ball_x+BALL_SIZE/2, ball_y+BALL_SIZE)
  - A probe is active when the extended h_cnt/v_cnt equal it. A probe beyond 2^CNT_W-1 never matches.
- Accumulate: each cycle with enable==1 and an active probe s, work[s][i] |= obj_hit[i]. Hits stay sticky within the frame. Multiple probes may be active in one cycle (degenerate BALL_SIZE==0); each is updated.
- Publish event P: (v_cnt==SYNC_LINE && h_cnt==0). On the P cycle:
  - col_obj <= work; col_side <= per-side OR; col_first <= per-side priority encode (lowest index wins).
  - col_valid <= 1.
  - work <= this cycle's hits only. A hit on the P pixel belongs to the next frame.
- Handshake:
  - col_ack with col_valid==1 and no P: col_valid <= 0 next cycle. Data outputs hold their values.
  - P with col_valid==1 and no ack the same cycle: overrun <= 1 (sticky until reset); report overwritten.
  - P and ack in the same cycle: new report loaded, col_valid stays 1, no overrun.
  - Ack with col_valid==0: ignored.
- Latency: report visible the cycle after P; 1-cycle register stage from obj_hit to work.
- enable==0: no accumulation; P still publishes (all-zero report if disabled all frame).
- Reset mid-frame: work cleared; next P publishes only post-reset hits.
- ball_x/ball_y may change at any time; probes use the current values each cycle (Ball updates once per frame after P).

Decomposition:
- Package collision_pkg:
  - SIDE_L=0, SIDE_R=1, SIDE_T=2, SIDE_B=3, NUM_SIDES=4.
  - Priority-encode function for col_first.
- Sub-module edge_probe (one instance per side):
  - Inputs: h_cnt, v_cnt, probe x/y.
  - Output: registered active flag.
  - Owns the widened compare.

Test Plan:
- Reset: rst=0 with obj_hit all 1s and a probe active -> all outputs 0; after release, first P gives col_valid=1, col_side=0.
- Single hit: NUM_OBJ=3, ball (100,200), obj_hit[1]=1 only at (100,208) -> after P: col_side=4'b0001, col_obj bit 1 set, col_first[SIDE_L]=1, others 0.
- Priority: obj 0 and obj 2 both hit at bottom probe (108,216) -> col_side[3]=1, col_first[SIDE_B]=0, col_obj bits 9 and 11 set.
- Handshake/overrun: no ack across two P events -> overrun=1, second report shown; ack same cycle as third P -> col_valid stays 1, overrun unchanged.
- Boundary: ball_x=1015, BALL_SIZE=16 -> right probe at 1031 never matches (h_cnt wraps at 1023), col_side[1]=0; hit exactly at P pixel appears in the following report, not the current one.
- enable=0 all frame with hits on all probes -> next report all zeros, col_valid=1.
